ps2_keyboard_rx: RTL

PS/2 device-to-host receiver that feeds the pong display/game block its keyboard strobe (ps2_done) and scan code (ps2_data).
- Synchronises and filters the raw PS/2 clock/data lines and deframes 11-bit frames.
- Checks start, parity and stop bits.
- Strips break (F0) and extended (E0) prefixes, so downstream sees exactly one pulse per key make.
- Sits between the board PS/2 pins and the display block.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_filter.sv | 48 ++++
 rtl/ps2_keyboard_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, deframe state encoding and the held-key mapping for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] KEY_Q     = 8'h15;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_L     = 8'h4B;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  // One-hot position of a tracked key in key_held ({L,P,A,Q}); zero for untracked codes.
  function automatic logic [3:0] hold_bit(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      KEY_Q:   m = 4'b0001;
      KEY_A:   m = 4'b0010;
      KEY_P:   m = 4'b0100;
      KEY_L:   m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 pins, glitch-filters the clock and emits a one-cycle pulse
// on each filtered falling edge, alongside the synchronised data line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic fall,
  output logic dat_s
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_f;
  logic [CW-1:0] fcnt;

  // fcnt counts consecutive samples that disagree with the filtered level; the line
  // is binary, so these are also consecutive equal samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync <= 2'b00;
      dat_sync <= 2'b00;
      clk_f    <= 1'b1;
      fcnt     <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_dat_i};
      fall     <= 1'b0;
      if (clk_sync[1] == clk_f) begin
        fcnt <= '0;
      end else if (fcnt == CW'(FILTER_LEN - 1)) begin
        clk_f <= clk_sync[1];
        fcnt  <= '0;
        fall  <= clk_f;
      end else begin
        fcnt <= fcnt + CW'(1);
      end
    end
  end

  assign dat_s = dat_sync[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks start/parity/stop and strips
// F0/E0 prefixes so one ps2_done pulse marks each key make. Optional held-key tracking: PS2_HOLD_EN.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_done,
  output logic [7:0] ps2_data,
  output logic       ps2_ext,
  output logic       frame_err,
  output logic [3:0] key_held
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          fall;
  logic          dat_s;
  rx_state_e     state, state_nx;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          tmo;
  logic          byte_valid;
  logic          err_nx;
  logic          brk;
  logic          ext;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .rstn      (rstn),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .fall      (fall),
    .dat_s     (dat_s)
  );

  // A fall in the timeout cycle keeps the frame alive.
  assign tmo = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1)) && !fall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    byte_valid = 1'b0;
    err_nx     = 1'b0;
    if (fall) begin
      case (state)
        IDLE:   if (!dat_s) state_nx = DATA;
        DATA:   if (bitcnt == 3'd7) state_nx = PARITY;
        PARITY: state_nx = STOP;
        STOP: begin
          state_nx = IDLE;
          if ((^shreg ^ par) && dat_s) byte_valid = 1'b1;
          else                         err_nx     = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end else if (tmo) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bitcnt <= 3'd0;
      shreg  <= 8'h00;
      par    <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (fall)                               tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYC - 1))  tcnt <= tcnt + TW'(1);
      if (fall) begin
        case (state)
          IDLE:    bitcnt <= 3'd0;
          DATA: begin
            shreg  <= {dat_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY:  par <= dat_s;
          default: ;
        endcase
      end
    end
  end

  // Prefix decoder; ps2_data only ever loads a complete, valid make code.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ps2_done  <= 1'b0;
      ps2_data  <= 8'h00;
      ps2_ext   <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      ext       <= 1'b0;
    end else begin
      ps2_done  <= 1'b0;
      frame_err <= err_nx;
      if (byte_valid) begin
        if (shreg == PS2_BREAK) begin
          brk <= 1'b1;
        end else if (shreg == PS2_EXT) begin
          ext <= 1'b1;
        end else if (brk) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          ps2_done <= 1'b1;
          ps2_data <= shreg;
          ps2_ext  <= ext;
          ext      <= 1'b0;
        end
      end
    end
  end

`ifdef PS2_HOLD_EN
  logic [3:0] held;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held <= 4'b0000;
    end else if (byte_valid && shreg != PS2_BREAK && shreg != PS2_EXT && !ext) begin
      if (brk) held <= held & ~hold_bit(shreg);
      else     held <= held | hold_bit(shreg);
    end
  end

  assign key_held = held;
`else
  assign key_held = 4'b0000;
`endif

endmodule
